// File: rtl/systolic_ws_engine_if.sv
// systolic_ws_engine_if: weight-load, activation-in and result-out bundle for systolic_ws_engine
// Ports: w_valid/w_ready/w_row weight rows, in_valid/in_ready/in_data activations,
// out_valid/out_data results, busy status; master = source/sink side, slave = engine side.
interface systolic_ws_engine_if #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_W      = 2*DATA_WIDTH+$clog2(ROWS)
);
    logic                        w_valid;
    logic                        w_ready;
    logic [COLS*DATA_WIDTH-1:0]  w_row;
    logic                        in_valid;
    logic                        in_ready;
    logic [ROWS*DATA_WIDTH-1:0]  in_data;
    logic                        out_valid;
    logic [COLS*ACC_W-1:0]       out_data;
    logic                        busy;
    modport master (output w_valid, w_row, in_valid, in_data,
                    input  w_ready, in_ready, out_valid, out_data, busy);
    modport slave  (input  w_valid, w_row, in_valid, in_data,
                    output w_ready, in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/systolic_ws_engine.sv
// systolic_ws_engine: weight-stationary ROWS x COLS systolic matrix-vector engine with load/compute control
// Ports: clk, reset (synchronous, active-high); bus (slave) carries the weight-row port, the
// activation port, the de-skewed result vector with its one-cycle valid, and busy.
module systolic_ws_engine #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_W      = 2*DATA_WIDTH+$clog2(ROWS),
    parameter bit SIGNED     = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    systolic_ws_engine_if.slave bus
);
    localparam int DW  = DATA_WIDTH;
    localparam int LAT = ROWS + COLS;
    localparam int CW  = $clog2(LAT + 1);
    typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;
    state_t                state_q, state_d;
    logic                  loaded_q, loaded_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LAT-1:0]        vld_q, vld_d;
    logic                  out_valid_q, out_valid_d;
    logic [COLS*ACC_W-1:0] out_q, out_d;
    logic [DW-1:0]         w_q   [ROWS][COLS], w_d   [ROWS][COLS];
    logic [DW-1:0]         sk_q  [ROWS][ROWS], sk_d  [ROWS][ROWS];
    logic [DW-1:0]         act_q [ROWS][COLS], act_d [ROWS][COLS];
    logic [ACC_W-1:0]      ps_q  [ROWS][COLS], ps_d  [ROWS][COLS];
    logic [ACC_W-1:0]      ds_q  [COLS][COLS], ds_d  [COLS][COLS];
    logic                  w_acc, in_acc;
    logic [CW-1:0]         row_idx;

    assign bus.w_ready   = state_q != BUSY;
    assign bus.in_ready  = state_q == BUSY || (state_q == IDLE && loaded_q && !bus.w_valid);
    assign bus.busy      = state_q != IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
    assign w_acc   = bus.w_valid && bus.w_ready;
    assign in_acc  = bus.in_valid && bus.in_ready;
    // cnt_q counts loaded rows in LOAD and remaining drain cycles in BUSY
    assign row_idx = state_q == IDLE ? '0 : cnt_q;

    // operands extended by one bit so a single signed multiply serves both signed and unsigned modes
    function automatic logic [ACC_W-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] w);
        logic signed [DW:0] ae, we;
        ae = {SIGNED & a[DW-1], a};
        we = {SIGNED & w[DW-1], w};
        return ACC_W'(ae) * ACC_W'(we);
    endfunction

    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (w_acc) begin
                state_d  = ROWS == 1 ? IDLE : LOAD;
                loaded_d = ROWS == 1 ? 1'b1 : loaded_q;
                cnt_d    = CW'(1);
            end else if (in_acc) begin
                state_d = BUSY;
                cnt_d   = CW'(LAT);
            end
            LOAD: if (w_acc) begin
                state_d  = cnt_q == CW'(ROWS - 1) ? IDLE : LOAD;
                loaded_d = cnt_q == CW'(ROWS - 1) || loaded_q;
                cnt_d    = cnt_q + CW'(1);
            end
            default: begin
                cnt_d   = in_acc ? CW'(LAT) : cnt_q - CW'(1);
                state_d = !in_acc && cnt_q == CW'(1) ? IDLE : BUSY;
            end
        endcase
    end

    always_comb begin
        vld_d       = {vld_q[LAT-2:0], in_acc};
        out_valid_d = vld_q[LAT-1];
        out_d       = out_q;
        for (int r = 0; r < ROWS; r++) begin
            // row r sees its activation r cycles late so each wavefront meets the matching partial sum
            for (int k = 0; k < ROWS; k++)
                sk_d[r][k] = k == 0 ? bus.in_data[r*DW +: DW] : sk_q[r][k == 0 ? 0 : k - 1];
            for (int c = 0; c < COLS; c++) begin
                w_d[r][c]   = w_acc && row_idx == CW'(r) ? bus.w_row[c*DW +: DW] : w_q[r][c];
                act_d[r][c] = c == 0 ? sk_q[r][r] : act_q[r][c == 0 ? 0 : c - 1];
                ps_d[r][c]  = (r == 0 ? '0 : ps_q[r == 0 ? 0 : r - 1][c]) + mul(act_d[r][c], w_q[r][c]);
            end
        end
        // column c leaves the bottom row c cycles after column 0; delay it COLS-1-c to realign
        for (int c = 0; c < COLS; c++) begin
            for (int k = 0; k < COLS; k++)
                ds_d[c][k] = k == 0 ? ps_q[ROWS-1][c] : ds_q[c][k == 0 ? 0 : k - 1];
            if (vld_q[LAT-1])
                out_d[c*ACC_W +: ACC_W] = c == COLS - 1 ? ps_q[ROWS-1][c] : ds_q[c][c == COLS - 1 ? 0 : COLS - 2 - c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            loaded_q    <= 1'b0;
            cnt_q       <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            w_q         <= '{default: '0};
            sk_q        <= '{default: '0};
            act_q       <= '{default: '0};
            ps_q        <= '{default: '0};
            ds_q        <= '{default: '0};
        end else begin
            state_q     <= state_d;
            loaded_q    <= loaded_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            w_q         <= w_d;
            sk_q        <= sk_d;
            act_q       <= act_d;
            ps_q        <= ps_d;
            ds_q        <= ds_d;
        end
    end
endmodule

// File: tb/tb_systolic_ws_engine.sv
// tb_systolic_ws_engine: directed checks of a signed and an unsigned 4x4 engine driven in lockstep
module tb_systolic_ws_engine;
    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        w_valid  = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] w_row    = '0;
    logic [15:0] in_data  = '0;
    int          cyc      = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          oq_cyc [$];
    logic [1:0]  oq_v   [$];
    logic [39:0] oq_s   [$];
    logic [31:0] oq_u   [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_ws_engine_if #(.ROWS(4), .COLS(4), .DATA_WIDTH(4), .ACC_W(10)) si ();
    systolic_ws_engine_if #(.ROWS(4), .COLS(4), .DATA_WIDTH(4), .ACC_W(8))  ui ();
    assign si.w_valid  = w_valid;
    assign si.w_row    = w_row;
    assign si.in_valid = in_valid;
    assign si.in_data  = in_data;
    assign ui.w_valid  = w_valid;
    assign ui.w_row    = w_row;
    assign ui.in_valid = in_valid;
    assign ui.in_data  = in_data;

    systolic_ws_engine #(.ROWS(4), .COLS(4), .DATA_WIDTH(4), .ACC_W(10), .SIGNED(1'b1)) u_s (
        .clk(clk), .reset(reset), .bus(si.slave));
    systolic_ws_engine #(.ROWS(4), .COLS(4), .DATA_WIDTH(4), .ACC_W(8), .SIGNED(1'b0)) u_u (
        .clk(clk), .reset(reset), .bus(ui.slave));

    always @(negedge clk)
        if (si.out_valid || ui.out_valid) begin
            oq_cyc.push_back(cyc);
            oq_v.push_back({si.out_valid, ui.out_valid});
            oq_s.push_back(si.out_data);
            oq_u.push_back(ui.out_data);
        end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] p4(input int e0, input int e1, input int e2, input int e3);
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    function automatic logic [39:0] ps(input int e0, input int e1, input int e2, input int e3);
        return {10'(e3), 10'(e2), 10'(e1), 10'(e0)};
    endfunction

    function automatic logic [31:0] pu(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic load(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r3);
        logic [15:0] rows [4];
        rows = '{r0, r1, r2, r3};
        for (int k = 0; k < 4; k++) begin
            w_valid = 1'b1;
            w_row   = rows[k];
            step();
            chk("load_busy", si.busy, k < 3);
        end
        w_valid = 1'b0;
        #1;
        chk("load_in_ready", si.in_ready, 1'b1);
    endtask

    task automatic send(input logic [15:0] v, output int e);
        in_valid = 1'b1;
        in_data  = v;
        #1;
        chk("send_in_ready", si.in_ready, 1'b1);
        step();
        e        = cyc;
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int ecyc, input logic [39:0] es, input logic [31:0] eu);
        chk({tag, "_present"}, oq_cyc.size() > 0, 1'b1);
        if (oq_cyc.size() > 0) begin
            chk({tag, "_cycle"}, oq_cyc.pop_front(), ecyc);
            chk({tag, "_valid"}, oq_v.pop_front(), 2'b11);
            chk({tag, "_signed"}, oq_s.pop_front(), es);
            chk({tag, "_unsigned"}, oq_u.pop_front(), eu);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, e2;
        step();
        step();
        chk("rst_out_valid", si.out_valid, 1'b0);
        chk("rst_out_data", si.out_data, '0);
        chk("rst_busy", si.busy, 1'b0);
        chk("rst_w_ready", si.w_ready, 1'b1);
        chk("rst_in_ready", si.in_ready, 1'b0);
        reset = 1'b0;

        in_valid = 1'b1;
        in_data  = p4(1, 1, 1, 1);
        step();
        step();
        chk("noload_in_ready", si.in_ready, 1'b0);
        chk("noload_busy", si.busy, 1'b0);
        in_valid = 1'b0;

        load(p4(1, 0, 0, 0), p4(0, 1, 0, 0), p4(0, 0, 1, 0), p4(0, 0, 0, 1));
        send(p4(3, -2, 5, 7), e);
        repeat (10) step();
        chk_out("ident", e + 8, ps(3, -2, 5, 7), pu(3, 14, 5, 7));
        chk("ident_extra", oq_cyc.size(), 0);
        chk("hold_data", si.out_data, ps(3, -2, 5, 7));
        chk("hold_valid", si.out_valid, 1'b0);

        for (int k = 1; k <= 4; k++) send(p4(k, k, k, k), e);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 7) chk("b2b_busy_hi", si.busy, 1'b1);
        end
        chk("b2b_busy_lo", si.busy, 1'b0);
        repeat (2) step();
        for (int k = 1; k <= 4; k++) chk_out("b2b", e + 4 + k, ps(k, k, k, k), pu(k, k, k, k));
        chk("b2b_extra", oq_cyc.size(), 0);

        send(p4(1, 2, 3, 4), e);
        w_valid = 1'b1;
        w_row   = p4(8, 8, 8, 8);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("blk_w_ready", si.w_ready, k == 8);
        end
        chk("blk_idle", si.busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("blk_load_busy", si.busy, k < 3);
        end
        w_valid = 1'b0;
        chk_out("blk", e + 8, ps(1, 2, 3, 4), pu(1, 2, 3, 4));

        send(p4(8, 8, 8, 8), e);
        repeat (10) step();
        chk_out("neg", e + 8, ps(256, 256, 256, 256), pu(0, 0, 0, 0));

        load(p4(1, 1, 1, 1), p4(2, 2, 2, 2), p4(3, 3, 3, 3), p4(4, 4, 4, 4));
        send(p4(1, -1, 1, -1), e);
        repeat (10) step();
        chk_out("alt", e + 8, ps(-2, -2, -2, -2), pu(94, 94, 94, 94));

        load(p4(15, 15, 15, 15), p4(15, 15, 15, 15), p4(15, 15, 15, 15), p4(15, 15, 15, 15));
        send(p4(15, 15, 15, 15), e);
        step();
        send(p4(15, 15, 15, 15), e2);
        repeat (12) step();
        chk_out("bub0", e + 8, ps(4, 4, 4, 4), pu(132, 132, 132, 132));
        chk_out("bub1", e + 10, ps(4, 4, 4, 4), pu(132, 132, 132, 132));
        chk("bub_extra", oq_cyc.size(), 0);

        send(p4(1, 1, 1, 1), e);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_data", si.out_data, '0);
        repeat (12) step();
        chk("mid_rst_no_out", oq_cyc.size(), 0);
        chk("mid_rst_in_ready", si.in_ready, 1'b0);
        chk("mid_rst_busy", si.busy, 1'b0);
        load(p4(1, 0, 0, 0), p4(0, 1, 0, 0), p4(0, 0, 1, 0), p4(0, 0, 0, 1));
        send(p4(3, -2, 5, 7), e);
        repeat (10) step();
        chk_out("reload", e + 8, ps(3, -2, 5, 7), pu(3, 14, 5, 7));
        chk("reload_extra", oq_cyc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
